// File: rtl/pe_lane_array_pkg.sv
// Shared types, constants and modular-arithmetic helpers for the butterfly lane array.
package pe_lane_array_pkg;

   localparam int COEFF_WIDTH = 12;
   localparam int KYBER_Q     = 3329;
   localparam int PIPE_DEPTH  = 4;

   localparam int LAT_NTT    = 4;
   localparam int LAT_INTT   = 4;
   localparam int LAT_CWM    = 4;
   localparam int LAT_CODECO = 3;
   localparam int LAT_ADDSUB = 1;

   typedef logic [COEFF_WIDTH-1:0] coeff_t;

   typedef enum logic [2:0] {
      PE_MODE_NTT,
      PE_MODE_INTT,
      PE_MODE_CWM,
      PE_MODE_CODECO1,
      PE_MODE_CODECO2,
      PE_MODE_ADDSUB
   } pe_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } pe_state_e;

   localparam logic [12:0] Q13 = 13'(KYBER_Q);
   localparam logic [23:0] Q24 = 24'(KYBER_Q);

   // Pipeline stage index (latency - 1) whose contents are presented at the output.
   function automatic logic [1:0] lat_tap(pe_mode_e m);
      case (m)
         PE_MODE_NTT:                     return 2'(LAT_NTT - 1);
         PE_MODE_INTT:                    return 2'(LAT_INTT - 1);
         PE_MODE_CWM:                     return 2'(LAT_CWM - 1);
         PE_MODE_CODECO1, PE_MODE_CODECO2: return 2'(LAT_CODECO - 1);
         default:                         return 2'(LAT_ADDSUB - 1);
      endcase
   endfunction

   function automatic coeff_t mod_add(coeff_t x, coeff_t y);
      logic [12:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= Q13) s = s - Q13;
      return coeff_t'(s);
   endfunction

   function automatic coeff_t mod_sub(coeff_t x, coeff_t y);
      logic [12:0] s;
      s = {1'b0, x} - {1'b0, y};
      if (x < y) s = s + Q13;
      return coeff_t'(s);
   endfunction

   function automatic coeff_t mod_mul(coeff_t x, coeff_t y);
      return coeff_t'(({12'b0, x} * {12'b0, y}) % Q24);
   endfunction

   // Division by 2 mod q: odd values borrow one q to become even.
   function automatic coeff_t mod_half(coeff_t x);
      return x[0] ? coeff_t'(({1'b0, x} + Q13) >> 1) : coeff_t'(x >> 1);
   endfunction

endpackage

// File: rtl/pe_lane_array_if.sv
// Operand/result bus of the lane array: input beat handshake, output beat handshake, status.
interface pe_lane_array_if #(parameter int NUM_LANES = 4);
   import pe_lane_array_pkg::*;

   coeff_t   a_i [NUM_LANES];
   coeff_t   b_i [NUM_LANES];
   coeff_t   w_i [NUM_LANES];
   pe_mode_e mode_i;
   logic     valid_i;
   logic     ready_o;
   coeff_t   u_o [NUM_LANES];
   coeff_t   v_o [NUM_LANES];
   logic     valid_o;
   logic     ready_i;
   logic     busy_o;
   pe_mode_e cur_mode_o;

   modport slave (
      input  a_i, b_i, w_i, mode_i, valid_i, ready_i,
      output ready_o, u_o, v_o, valid_o, busy_o, cur_mode_o
   );

   modport master (
      output a_i, b_i, w_i, mode_i, valid_i, ready_i,
      input  ready_o, u_o, v_o, valid_o, busy_o, cur_mode_o
   );
endinterface

// File: rtl/pe_lane_array_lane.sv
// Single butterfly lane: combinational mod-q result captured into a 4-deep shift pipeline
// that freezes when en_i is low; tap_i picks the stage matching the active mode's latency.
module pe_lane
   import pe_lane_array_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  pe_mode_e   mode_i,
   input  logic [1:0] tap_i,
   input  coeff_t     a_i,
   input  coeff_t     b_i,
   input  coeff_t     w_i,
   output coeff_t     u_o,
   output coeff_t     v_o
);

   coeff_t bw, res_u, res_v;
   coeff_t u_q [PIPE_DEPTH];
   coeff_t u_d [PIPE_DEPTH];
   coeff_t v_q [PIPE_DEPTH];
   coeff_t v_d [PIPE_DEPTH];

   always_comb begin
      bw    = mod_mul(b_i, w_i);
      res_u = mod_add(a_i, b_i);
      res_v = mod_sub(a_i, b_i);
      case (mode_i)
         PE_MODE_NTT, PE_MODE_CWM: begin
            res_u = mod_add(a_i, bw);
            res_v = mod_sub(a_i, bw);
         end
         PE_MODE_INTT: begin
            res_u = mod_half(mod_add(a_i, b_i));
            res_v = mod_mul(mod_sub(a_i, b_i), w_i);
         end
         PE_MODE_CODECO1, PE_MODE_CODECO2: begin
            res_u = a_i;
            res_v = bw;
         end
         default: ;
      endcase
   end

   always_comb begin
      u_d = u_q;
      v_d = v_q;
      if (en_i) begin
         u_d[0] = res_u;
         v_d[0] = res_v;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            u_d[k] = u_q[k-1];
            v_d[k] = v_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u_q <= '{default: '0};
         v_q <= '{default: '0};
      end else begin
         u_q <= u_d;
         v_q <= v_d;
      end
   end

   assign u_o = u_q[tap_i];
   assign v_o = v_q[tap_i];

endmodule

// File: rtl/pe_lane_array.sv
// Lockstep array of butterfly lanes with shared mode FSM, occupancy and valid pipeline.
// Optional performance counters are enabled with `define PE_LANE_ARRAY_PERF_CNT_EN.
//
// state    | meaning
// ST_IDLE  | empty; any mode may be accepted and becomes cur_mode
// ST_RUN   | accepting beats of cur_mode only
// ST_DRAIN | new mode waiting; no accepts until pipeline is empty
module pe_lane_array
   import pe_lane_array_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pe_lane_array_if.slave       bus
`ifdef PE_LANE_ARRAY_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] beat_cnt_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o
`endif
);

   if (NUM_LANES < 1 || NUM_LANES > 16 || CNT_WIDTH < 1) begin : g_param_check
      $error("pe_lane_array: parameter out of range");
   end

   pe_state_e        state_q, state_d;
   pe_mode_e         cur_mode_q, cur_mode_d;
   logic [2:0]       occ_q, occ_d;
   logic [PIPE_DEPTH-1:0] vld_q, vld_d;
   logic [1:0]       tap;
   logic             valid_out, stall, adv, rdy, accept, deliver;
   coeff_t           lane_u [NUM_LANES];
   coeff_t           lane_v [NUM_LANES];

   assign tap       = lat_tap(cur_mode_q);
   assign valid_out = vld_q[tap];
   assign stall     = valid_out & ~bus.ready_i;
   assign adv       = ~stall;
   assign accept    = bus.valid_i & bus.ready_o;
   assign deliver   = valid_out & bus.ready_i;

   always_comb begin
      rdy = 1'b0;
      case (state_q)
         ST_IDLE: rdy = 1'b1;
         ST_RUN:  rdy = ~stall & (bus.mode_i == cur_mode_q);
         default: rdy = 1'b0;
      endcase
   end

   // Stages past the active tap are cleared so leftovers never surface after a mode change.
   always_comb begin
      vld_d = vld_q;
      occ_d = occ_q + {2'b0, accept} - {2'b0, deliver};
      if (adv) begin
         vld_d[0] = accept;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            vld_d[k] = vld_q[k-1] & (2'(k) <= tap);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_mode_d = cur_mode_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cur_mode_d = bus.mode_i;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.valid_i && bus.mode_i != cur_mode_q) state_d = ST_DRAIN;
            else if (!bus.valid_i && occ_d == 3'd0)     state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (occ_q == 3'd0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cur_mode_q <= PE_MODE_ADDSUB;
         occ_q      <= 3'd0;
         vld_q      <= '0;
      end else begin
         state_q    <= state_d;
         cur_mode_q <= cur_mode_d;
         occ_q      <= occ_d;
         vld_q      <= vld_d;
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      pe_lane u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_i   (adv),
         .mode_i (bus.mode_i),
         .tap_i  (tap),
         .a_i    (bus.a_i[l]),
         .b_i    (bus.b_i[l]),
         .w_i    (bus.w_i[l]),
         .u_o    (lane_u[l]),
         .v_o    (lane_v[l])
      );
   end

   assign bus.ready_o    = rdy & rst_n;
   assign bus.valid_o    = valid_out;
   assign bus.u_o        = lane_u;
   assign bus.v_o        = lane_v;
   assign bus.busy_o     = (occ_q != 3'd0) | (state_q != ST_IDLE);
   assign bus.cur_mode_o = cur_mode_q;

`ifdef PE_LANE_ARRAY_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d, stall_cnt_q, stall_cnt_d;

   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (deliver && beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
      if ((stall || state_q == ST_DRAIN) && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign beat_cnt_o  = beat_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_lane_array.sv
// Directed self-checking bench for pe_lane_array; inputs change and outputs are sampled
// 1 time unit after the falling edge.
module tb_pe_lane_array;
   import pe_lane_array_pkg::*;

   localparam int NL = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   pe_lane_array_if #(.NUM_LANES(NL)) bus ();

`ifdef PE_LANE_ARRAY_PERF_CNT_EN
   logic [31:0] beat_cnt, stall_cnt;
`endif

   pe_lane_array #(.NUM_LANES(NL), .CNT_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef PE_LANE_ARRAY_PERF_CNT_EN
      ,
      .beat_cnt_o  (beat_cnt),
      .stall_cnt_o (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic set_ops(input pe_mode_e m, input coeff_t a, input coeff_t b, input coeff_t w,
                          input logic vld);
      for (int l = 0; l < NL; l++) begin
         bus.a_i[l] = a;
         bus.b_i[l] = b;
         bus.w_i[l] = w;
      end
      bus.mode_i  = m;
      bus.valid_i = vld;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      bus.valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Presents one beat, then idles; reports acceptance, latency and lane-0 result.
   task automatic single_beat(input pe_mode_e m, input coeff_t a, input coeff_t b, input coeff_t w,
                              output logic acc, output int lat, output coeff_t u, output coeff_t v);
      @(negedge clk);
      set_ops(m, a, b, w, 1'b1);
      bus.ready_i = 1'b1;
      #1;
      acc = bus.ready_o;
      lat = -1;
      u = '0;
      v = '0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.valid_i = 1'b0;
         #1;
         if (bus.valid_o && lat < 0) begin
            lat = k;
            u = bus.u_o[0];
            v = bus.v_o[0];
         end
      end
   endtask

   task automatic test_reset();
      set_ops(PE_MODE_NTT, 12'd0, 12'd0, 12'd0, 1'b0);
      bus.ready_i = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags valid_o=%b ready_o=%b busy_o=%b required 0 0 0",
                  bus.valid_o, bus.ready_o, bus.busy_o);
      end
      checks++;
      if (bus.u_o[0] !== 12'd0 || bus.v_o[0] !== 12'd0 || bus.cur_mode_o !== PE_MODE_ADDSUB) begin
         failures++;
         $display("FAIL reset_data u=%0d v=%0d mode=%0d required 0 0 %0d",
                  bus.u_o[0], bus.v_o[0], bus.cur_mode_o, PE_MODE_ADDSUB);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready ready_o=%b required 1", bus.ready_o);
      end
   endtask

   task automatic test_modes();
      logic acc;
      int lat;
      coeff_t u, v;
      single_beat(PE_MODE_NTT, 12'd1, 12'd2, 12'd3, acc, lat, u, v);
      checks++;
      if (acc !== 1'b1 || lat != 4 || u !== 12'd7 || v !== 12'd3324) begin
         failures++;
         $display("FAIL ntt acc=%b lat=%0d u=%0d v=%0d required 1 4 7 3324", acc, lat, u, v);
      end
      single_beat(PE_MODE_INTT, 12'd5, 12'd3, 12'd2, acc, lat, u, v);
      checks++;
      if (acc !== 1'b1 || lat != 4 || u !== 12'd4 || v !== 12'd4) begin
         failures++;
         $display("FAIL intt acc=%b lat=%0d u=%0d v=%0d required 1 4 4 4", acc, lat, u, v);
      end
      single_beat(PE_MODE_INTT, 12'd0, 12'd1, 12'd5, acc, lat, u, v);
      checks++;
      if (lat != 4 || u !== 12'd1665 || v !== 12'd3324) begin
         failures++;
         $display("FAIL intt_odd lat=%0d u=%0d v=%0d required 4 1665 3324", lat, u, v);
      end
      single_beat(PE_MODE_ADDSUB, 12'd3328, 12'd2, 12'd0, acc, lat, u, v);
      checks++;
      if (acc !== 1'b1 || lat != 1 || u !== 12'd1 || v !== 12'd3326) begin
         failures++;
         $display("FAIL addsub acc=%b lat=%0d u=%0d v=%0d required 1 1 1 3326", acc, lat, u, v);
      end
      single_beat(PE_MODE_CODECO1, 12'd10, 12'd100, 12'd40, acc, lat, u, v);
      checks++;
      if (lat != 3 || u !== 12'd10 || v !== 12'd671) begin
         failures++;
         $display("FAIL codeco1 lat=%0d u=%0d v=%0d required 3 10 671", lat, u, v);
      end
      single_beat(PE_MODE_CWM, 12'd3328, 12'd3328, 12'd1, acc, lat, u, v);
      checks++;
      if (lat != 4 || u !== 12'd3327 || v !== 12'd0) begin
         failures++;
         $display("FAIL cwm_edge lat=%0d u=%0d v=%0d required 4 3327 0", lat, u, v);
      end
   endtask

   task automatic test_lanes();
      coeff_t la [NL] = '{12'd3328, 12'd0, 12'd100, 12'd3000};
      coeff_t lb [NL] = '{12'd2, 12'd1, 12'd100, 12'd500};
      coeff_t eu [NL] = '{12'd1, 12'd1, 12'd200, 12'd171};
      coeff_t ev [NL] = '{12'd3326, 12'd3328, 12'd0, 12'd2500};
      @(negedge clk);
      set_ops(PE_MODE_ADDSUB, 12'd0, 12'd0, 12'd0, 1'b1);
      for (int l = 0; l < NL; l++) begin
         bus.a_i[l] = la[l];
         bus.b_i[l] = lb[l];
      end
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      for (int l = 0; l < NL; l++) begin
         checks++;
         if (bus.valid_o !== 1'b1 || bus.u_o[l] !== eu[l] || bus.v_o[l] !== ev[l]) begin
            failures++;
            $display("FAIL lane%0d valid=%b u=%0d v=%0d required 1 %0d %0d",
                     l, bus.valid_o, bus.u_o[l], bus.v_o[l], eu[l], ev[l]);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_mode_switch();
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         bus.ready_i = 1'b1;
         if (c == 0)      set_ops(PE_MODE_NTT, 12'd1, 12'd2, 12'd3, 1'b1);
         else if (c <= 6) set_ops(PE_MODE_ADDSUB, 12'd3328, 12'd2, 12'd0, 1'b1);
         else             bus.valid_i = 1'b0;
         #1;
         if (c >= 1 && c <= 5) begin
            checks++;
            if (bus.ready_o !== 1'b0) begin
               failures++;
               $display("FAIL switch_ready_c%0d ready_o=%b required 0", c, bus.ready_o);
            end
         end
         if (c == 0 || c == 6) begin
            checks++;
            if (bus.ready_o !== 1'b1) begin
               failures++;
               $display("FAIL switch_ready_c%0d ready_o=%b required 1", c, bus.ready_o);
            end
         end
         if (c == 4) begin
            checks++;
            if (bus.valid_o !== 1'b1 || bus.u_o[0] !== 12'd7 || bus.v_o[0] !== 12'd3324) begin
               failures++;
               $display("FAIL switch_ntt_out valid=%b u=%0d v=%0d required 1 7 3324",
                        bus.valid_o, bus.u_o[0], bus.v_o[0]);
            end
         end
         if (c == 5 || c == 6) begin
            checks++;
            if (bus.valid_o !== 1'b0) begin
               failures++;
               $display("FAIL switch_gap_c%0d valid_o=%b required 0", c, bus.valid_o);
            end
         end
         if (c == 6) begin
            checks++;
            if (bus.cur_mode_o !== PE_MODE_NTT) begin
               failures++;
               $display("FAIL switch_mode_c6 mode=%0d required %0d", bus.cur_mode_o, PE_MODE_NTT);
            end
         end
         if (c == 7) begin
            checks++;
            if (bus.valid_o !== 1'b1 || bus.u_o[0] !== 12'd1 || bus.v_o[0] !== 12'd3326 ||
                bus.cur_mode_o !== PE_MODE_ADDSUB) begin
               failures++;
               $display("FAIL switch_addsub_out valid=%b u=%0d v=%0d mode=%0d required 1 1 3326 %0d",
                        bus.valid_o, bus.u_o[0], bus.v_o[0], bus.cur_mode_o, PE_MODE_ADDSUB);
            end
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_stall();
      // CWM with w=2: u = a + 2b, v = a - 2b (mod q)
      coeff_t ia [8] = '{12'd1, 12'd101, 12'd201, 12'd301, 12'd401, 12'd501, 12'd601, 12'd701};
      coeff_t ib [8] = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
      coeff_t eu [8] = '{12'd3, 12'd105, 12'd207, 12'd309, 12'd411, 12'd513, 12'd615, 12'd717};
      coeff_t ev [8] = '{12'd3328, 12'd97, 12'd195, 12'd293, 12'd391, 12'd489, 12'd587, 12'd685};
      int in_idx = 0;
      int out_idx = 0;
      reset_dut();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         bus.ready_i = !(c >= 5 && c <= 7);
         if (in_idx < 8) set_ops(PE_MODE_CWM, ia[in_idx], ib[in_idx], 12'd2, 1'b1);
         else            bus.valid_i = 1'b0;
         #1;
         if (c >= 5 && c <= 7) begin
            checks++;
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) begin
               failures++;
               $display("FAIL stall_c%0d valid_o=%b ready_o=%b required 1 0", c, bus.valid_o, bus.ready_o);
            end
         end
         if (bus.valid_o === 1'b1) begin
            checks++;
            if (out_idx >= 8) begin
               failures++;
               $display("FAIL stream_extra beat=%0d required at most 8 beats", out_idx);
            end else if (bus.u_o[0] !== eu[out_idx] || bus.v_o[0] !== ev[out_idx] ||
                         bus.u_o[NL-1] !== eu[out_idx] || bus.v_o[NL-1] !== ev[out_idx]) begin
               failures++;
               $display("FAIL stream_beat%0d c=%0d u=%0d/%0d v=%0d/%0d required %0d %0d", out_idx, c,
                        bus.u_o[0], bus.u_o[NL-1], bus.v_o[0], bus.v_o[NL-1], eu[out_idx], ev[out_idx]);
            end
            if (bus.ready_i) out_idx++;
         end
         if (bus.valid_i && bus.ready_o) in_idx++;
      end
      checks++;
      if (in_idx != 8 || out_idx != 8) begin
         failures++;
         $display("FAIL stream_count accepted=%0d delivered=%0d required 8 8", in_idx, out_idx);
      end
`ifdef PE_LANE_ARRAY_PERF_CNT_EN
      checks++;
      if (beat_cnt !== 32'd8 || stall_cnt !== 32'd3) begin
         failures++;
         $display("FAIL perf_cnt beat=%0d stall=%0d required 8 3", beat_cnt, stall_cnt);
      end
`endif
   endtask

   task automatic test_reset_midflight();
      int stale = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.ready_i = 1'b1;
         set_ops(PE_MODE_NTT, coeff_t'(c + 1), 12'd1, 12'd1, 1'b1);
         #1;
         checks++;
         if (bus.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flight_accept_c%0d ready_o=%b required 1", c, bus.ready_o);
         end
      end
      @(negedge clk);
      bus.valid_i = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         failures++;
         $display("FAIL flight_in_reset valid=%b ready=%b busy=%b required 0 0 0",
                  bus.valid_o, bus.ready_o, bus.busy_o);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b1) begin
         failures++;
         $display("FAIL flight_release_ready ready_o=%b required 1", bus.ready_o);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (bus.valid_o !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0 || bus.busy_o !== 1'b0) begin
         failures++;
         $display("FAIL flight_stale stale_cycles=%0d busy=%b required 0 0", stale, bus.busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_lanes();
      test_mode_switch();
      test_stall();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
